compressor12_rr_arbiter: RTL and testbench

// - Shares one downstream compute resource (max-plus datapath unit) among 12 single-bit requesters.
// - Collects the 12 request wires into a vector, picks one with fair round-robin priority, and holds the grant until the resource signals completion.
// - Sits between the 12 requester cells and the shared unit; registered one-hot grant plus binary grant index.

---
 rtl/compressor12_rr_arbiter_pkg.sv | 19 +
 rtl/compressor12_rr_arbiter_if.sv | 23 ++
 rtl/compressor12_rr_arbiter_rr_pick.sv | 32 +++
 rtl/compressor12_rr_arbiter.sv | 117 +++++++++++
 tb/tb_compressor12_rr_arbiter.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/compressor12_rr_arbiter_pkg.sv
// Shared types and helpers for the 12-way round-robin arbiter in front of the max-plus unit.
package maxplus_arb_pkg;

    localparam int unsigned N_REQ_DEF = 12;
    localparam int unsigned ID_W_DEF  = 4;

    typedef enum logic {IDLE, BUSY} state_t;

    // Zero when no bit is set; the caller only consumes this when a winner exists.
    function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (oh[i]) idx = idx | 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/compressor12_rr_arbiter_if.sv
// Request/grant bundle between the requester cells (master) and the arbiter (slave).
interface compressor12_rr_arbiter_if #(
    parameter int unsigned N_REQ = 12,
    parameter int unsigned ID_W  = 4
);
    logic [N_REQ-1:0] req;
    logic             res_done;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_id;
    logic             grant_vld;
    logic             busy;
    logic             timeout;

    modport master (
        output req, res_done,
        input  grant, grant_id, grant_vld, busy, timeout
    );

    modport slave (
        input  req, res_done,
        output grant, grant_id, grant_vld, busy, timeout
    );
endinterface

// File: rtl/compressor12_rr_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set req bit at or after ptr, wrapping at N_REQ.
import maxplus_arb_pkg::*;

module rr_pick #(
    parameter int unsigned N_REQ = 12,
    parameter int unsigned ID_W  = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] win,
    output logic [ID_W-1:0]  idx,
    output logic             any
);
    int unsigned k;

    always_comb begin
        win = '0;
        any = 1'b0;
        k   = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            k = 32'(ptr) + i;
            if (k >= N_REQ) k = k - N_REQ;
            if (!any && req[k]) begin
                win[k] = 1'b1;
                any    = 1'b1;
            end
        end
    end

    assign idx = ID_W'(onehot_to_idx(16'(win)));

endmodule

// File: rtl/compressor12_rr_arbiter.sv
// Round-robin arbiter sharing one max-plus unit among N_REQ requesters; grant held until res_done.
// Optional forced release after TIMEOUT busy cycles when ARB_TIMEOUT_EN is defined.
import maxplus_arb_pkg::*;

module compressor12_rr_arbiter #(
    parameter int unsigned N_REQ   = N_REQ_DEF,
    parameter int unsigned ID_W    = ID_W_DEF,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    compressor12_rr_arbiter_if.slave bus
);
    state_t           state;
    logic [ID_W-1:0]  ptr;
    logic [N_REQ-1:0] grant_q;
    logic [ID_W-1:0]  grant_id_q;
    logic             grant_vld_q;
    logic [N_REQ-1:0] pick_win;
    logic [ID_W-1:0]  pick_idx;
    logic             pick_any;
    logic [ID_W-1:0]  next_ptr;

    rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
        .req (bus.req),
        .ptr (ptr),
        .win (pick_win),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign next_ptr = (grant_id_q == ID_W'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] cnt;
    logic             timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            grant_q     <= '0;
            grant_id_q  <= '0;
            grant_vld_q <= 1'b0;
            cnt         <= '0;
            timeout_q   <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant_q     <= pick_win;
                        grant_id_q  <= pick_idx;
                        grant_vld_q <= 1'b1;
                        cnt         <= '0;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    // res_done wins over a simultaneous expiry, so no timeout pulse then.
                    if (bus.res_done || (cnt == CNT_W'(TIMEOUT - 1))) begin
                        grant_q     <= '0;
                        grant_vld_q <= 1'b0;
                        ptr         <= next_ptr;
                        state       <= IDLE;
                        timeout_q   <= ~bus.res_done;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.timeout = timeout_q;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            grant_q     <= '0;
            grant_id_q  <= '0;
            grant_vld_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant_q     <= pick_win;
                        grant_id_q  <= pick_idx;
                        grant_vld_q <= 1'b1;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.res_done) begin
                        grant_q     <= '0;
                        grant_vld_q <= 1'b0;
                        ptr         <= next_ptr;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.timeout = 1'b0;
`endif

    assign bus.grant     = grant_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.grant_vld = grant_vld_q;
    assign bus.busy      = (state == BUSY);

endmodule

// File: tb/tb_compressor12_rr_arbiter.sv
// Directed self-checking bench for compressor12_rr_arbiter (timeout steps only with ARB_TIMEOUT_EN).
module tb_compressor12_rr_arbiter;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    compressor12_rr_arbiter_if #(.N_REQ(12), .ID_W(4)) bus ();

    compressor12_rr_arbiter #(.N_REQ(12), .ID_W(4), .TIMEOUT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [11:0] exp_gnt;

    initial begin
        errors       = 0;
        checks       = 0;
        rst_n        = 1'b0;
        bus.req      = 12'hFFF;
        bus.res_done = 1'b0;

        // reset with all requests asserted
        step();
        step();
        chk("rst_grant", 32'(bus.grant), 32'h000);
        chk("rst_vld",   32'(bus.grant_vld), 32'h0);
        chk("rst_busy",  32'(bus.busy), 32'h0);
        chk("rst_id",    32'(bus.grant_id), 32'h0);
        chk("rst_tmo",   32'(bus.timeout), 32'h0);

        rst_n = 1'b1;
        step();
        chk("first_grant", 32'(bus.grant), 32'h001);
        chk("first_id",    32'(bus.grant_id), 32'h0);
        chk("first_busy",  32'(bus.busy), 32'h1);

        // round robin 1..11 then wrap to 0
        for (int k = 1; k <= 12; k++) begin
            bus.res_done = 1'b1;
            step();
            chk("rr_bubble_vld", 32'(bus.grant_vld), 32'h0);
            bus.res_done = 1'b0;
            step();
            exp_gnt = 12'h001 << (k % 12);
            chk("rr_id",    32'(bus.grant_id), 32'(k % 12));
            chk("rr_grant", 32'(bus.grant), 32'(exp_gnt));
        end

        // move ptr to 10 via a grant to 9
        bus.req      = 12'h200;
        bus.res_done = 1'b1;
        step();
        bus.res_done = 1'b0;
        step();
        chk("to9_id", 32'(bus.grant_id), 32'h9);

        // wrap/skip: ptr=10, req=009 -> 0, then ptr=1 -> 3
        bus.req      = 12'h009;
        bus.res_done = 1'b1;
        step();
        bus.res_done = 1'b0;
        step();
        chk("wrap_id",    32'(bus.grant_id), 32'h0);
        chk("wrap_grant", 32'(bus.grant), 32'h001);
        bus.res_done = 1'b1;
        step();
        bus.res_done = 1'b0;
        step();
        chk("skip_id",    32'(bus.grant_id), 32'h3);
        chk("skip_grant", 32'(bus.grant), 32'h008);

        // hold: grant 5, req toggled during BUSY
        bus.req      = 12'h020;
        bus.res_done = 1'b1;
        step();
        bus.res_done = 1'b0;
        step();
        chk("hold_grant0", 32'(bus.grant), 32'h020);
        bus.req = 12'h000;
        step();
        chk("hold_grant1", 32'(bus.grant), 32'h020);
        bus.req = 12'h800;
        step();
        chk("hold_grant2", 32'(bus.grant), 32'h020);
        chk("hold_id2",    32'(bus.grant_id), 32'h5);
        bus.req = 12'h000;
        step();
        chk("hold_grant3", 32'(bus.grant), 32'h020);
        chk("hold_busy3",  32'(bus.busy), 32'h1);

        // simultaneous res_done and new request (also coincides with 4th busy cycle)
        bus.req      = 12'h004;
        bus.res_done = 1'b1;
        step();
        bus.res_done = 1'b0;
        chk("sim_bubble_grant", 32'(bus.grant), 32'h000);
        chk("sim_bubble_busy",  32'(bus.busy), 32'h0);
        chk("sim_no_tmo",       32'(bus.timeout), 32'h0);
        step();
        chk("sim_grant", 32'(bus.grant), 32'h004);
        chk("sim_id",    32'(bus.grant_id), 32'h2);

        // release, then res_done in IDLE is ignored
        bus.req      = 12'h000;
        bus.res_done = 1'b1;
        step();
        step();
        chk("idle_done_busy",  32'(bus.busy), 32'h0);
        chk("idle_done_grant", 32'(bus.grant), 32'h000);
        bus.res_done = 1'b0;
        bus.req      = 12'h018;
        step();
        chk("post_idle_id", 32'(bus.grant_id), 32'h3);

        // asynchronous reset in the middle of BUSY
        bus.req = 12'hFFF;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_grant", 32'(bus.grant), 32'h000);
        chk("async_busy",  32'(bus.busy), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("after_rst_id",    32'(bus.grant_id), 32'h0);
        chk("after_rst_grant", 32'(bus.grant), 32'h001);

        bus.req = 12'h000;
`ifdef ARB_TIMEOUT_EN
        // TIMEOUT=4: forced release after 4 busy cycles
        step();
        chk("tmo_busy1", 32'(bus.busy), 32'h1);
        step();
        chk("tmo_busy2", 32'(bus.busy), 32'h1);
        step();
        chk("tmo_busy3", 32'(bus.busy), 32'h1);
        chk("tmo_pre",   32'(bus.timeout), 32'h0);
        step();
        chk("tmo_release", 32'(bus.grant_vld), 32'h0);
        chk("tmo_pulse",   32'(bus.timeout), 32'h1);
        step();
        chk("tmo_pulse_end", 32'(bus.timeout), 32'h0);
        bus.req = 12'hFFF;
        step();
        chk("tmo_ptr_id", 32'(bus.grant_id), 32'h1);
`else
        // without the timeout feature BUSY persists until res_done
        for (int i = 0; i < 8; i++) step();
        chk("notmo_busy",  32'(bus.busy), 32'h1);
        chk("notmo_grant", 32'(bus.grant), 32'h001);
        chk("notmo_tmo",   32'(bus.timeout), 32'h0);
        bus.res_done = 1'b1;
        step();
        bus.res_done = 1'b0;
        bus.req      = 12'hFFF;
        step();
        chk("notmo_ptr_id", 32'(bus.grant_id), 32'h1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
